// File: rtl/div_issue_queue_pkg.sv
// Shared types for the divider issue queue: FSM states, the queued request
// record and the divide-by-zero quotient constant.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_TAGW  = 4;

  // Quotient reported for a zero divisor (all ones, like a saturated result).
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } div_q_state_e;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_TAGW-1:0]  tag;
  } div_req_t;

endpackage

// File: rtl/div_issue_queue_if.sv
// Request, divider and response signals of the divider issue queue.
// The queue itself connects through the slave modport; its environment
// (producer, divider, consumer) through the master modport.
interface div_issue_queue_if #(
  parameter int WIDTH = 8,
  parameter int TAGW  = 4
);

  logic             ReqVal;
  logic             ReqRdy;
  logic [WIDTH-1:0] ReqDividend;
  logic [WIDTH-1:0] ReqDivisor;
  logic [TAGW-1:0]  ReqTag;

  logic             DivDataVal;
  logic [WIDTH-1:0] DivDividend;
  logic [WIDTH-1:0] DivDivisor;
  logic             DivResultVal;
  logic [WIDTH-1:0] DivQuotient;
  logic [WIDTH-1:0] DivRemainder;

  logic             RspVal;
  logic             RspRdy;
  logic [WIDTH-1:0] RspQuotient;
  logic [WIDTH-1:0] RspRemainder;
  logic [TAGW-1:0]  RspTag;
  logic             RspDivZero;
  logic             RspTimeout;

  modport slave (
    input  ReqVal, ReqDividend, ReqDivisor, ReqTag,
    output ReqRdy,
    output DivDataVal, DivDividend, DivDivisor,
    input  DivResultVal, DivQuotient, DivRemainder,
    output RspVal, RspQuotient, RspRemainder, RspTag, RspDivZero, RspTimeout,
    input  RspRdy
  );

  modport master (
    output ReqVal, ReqDividend, ReqDivisor, ReqTag,
    input  ReqRdy,
    input  DivDataVal, DivDividend, DivDivisor,
    output DivResultVal, DivQuotient, DivRemainder,
    input  RspVal, RspQuotient, RspRemainder, RspTag, RspDivZero, RspTimeout,
    output RspRdy
  );

endinterface

// File: rtl/div_req_fifo.sv
// In-order request FIFO. Push is ignored when full and pop when empty;
// pointers wrap naturally because DEPTH is a power of two.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  div_req_t                 pushData,
  input  logic                     pop,
  output div_req_t                 popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  div_req_t        mem [DEPTH];
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;
  logic            doPush;
  logic            doPop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; entries are only read after
  // being written, and a resettable array would cost a flop-reset per bit.
  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/div_issue_queue.sv
// Front end for the iterative divider: buffers tagged requests, issues one
// at a time with a single-cycle DivDataVal pulse, resolves divide-by-zero
// locally and converts a missing divider result into a timeout response.
module div_issue_queue
  import div_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TAGW    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  div_issue_queue_if.slave  bus
);

  localparam int               WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT - 1);

  div_q_state_e                state;
  div_req_t                    opReg;
  logic [WDW-1:0]              wdCnt;
  logic [WIDTH-1:0]            rspQuot;
  logic [WIDTH-1:0]            rspRem;
  logic                        rspDivZero;
  logic                        rspTimeout;

  div_req_t                    pushReq;
  div_req_t                    headReq;
  logic                        fifoFull;
  logic                        fifoEmpty;
  logic [$clog2(DEPTH):0]      fifoCount;
  logic                        popHead;

  assign pushReq = '{dividend: bus.ReqDividend, divisor: bus.ReqDivisor, tag: bus.ReqTag};
  assign popHead = (state == IDLE) && !fifoEmpty;

  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (bus.ReqVal),
    .pushData (pushReq),
    .pop      (popHead),
    .popData  (headReq),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // Consistency between the FIFO's empty flag and its occupancy count.
  always_comb begin
    assert (fifoEmpty == (fifoCount == '0));
  end

  // No same-cycle bypass: a pop does not free a slot for this cycle's push.
  assign bus.ReqRdy       = ~fifoFull;

  assign bus.DivDataVal   = (state == ISSUE);
  assign bus.DivDividend  = opReg.dividend;
  assign bus.DivDivisor   = opReg.divisor;

  assign bus.RspVal       = (state == HOLD);
  assign bus.RspQuotient  = rspQuot;
  assign bus.RspRemainder = rspRem;
  assign bus.RspTag       = opReg.tag;
  assign bus.RspDivZero   = rspDivZero;
  assign bus.RspTimeout   = rspTimeout;

  // Issue FSM with operation register, watchdog and response registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      opReg      <= '0;
      wdCnt      <= '0;
      rspQuot    <= '0;
      rspRem     <= '0;
      rspDivZero <= 1'b0;
      rspTimeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (popHead) begin
            opReg <= headReq;
            if (headReq.divisor == '0) begin
              rspQuot    <= DIV_ZERO_QUOT;
              rspRem     <= headReq.dividend;
              rspDivZero <= 1'b1;
              rspTimeout <= 1'b0;
              state      <= HOLD;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wdCnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result on the final watchdog cycle still wins over the timeout.
          if (bus.DivResultVal) begin
            rspQuot    <= bus.DivQuotient;
            rspRem     <= bus.DivRemainder;
            rspDivZero <= 1'b0;
            rspTimeout <= 1'b0;
            state      <= HOLD;
          end else if (wdCnt == WD_LAST) begin
            rspQuot    <= '0;
            rspRem     <= '0;
            rspDivZero <= 1'b0;
            rspTimeout <= 1'b1;
            state      <= HOLD;
          end else begin
            wdCnt <= wdCnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.RspRdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_issue_queue.md
Name: div_issue_queue

Overview:
- Request-side front end that sits directly upstream of the team's iterative unsigned integer divider.
- Buffers tagged divide requests from a valid/ready producer in an in-order FIFO and issues them one at a time to the divider.
- Issue uses a single-cycle DivDataVal pulse. The queue captures the divider's result pulse and returns a tagged response on a valid/ready consumer port.
- Divide-by-zero requests are resolved locally and never sent to the divider. A watchdog converts a missing divider result into a timeout response.

Parameters:
- WIDTH, 8, operand and result width; must match the divider's WIDTH.
- TAGW, 4, request tag width.
- DEPTH, 4, FIFO entries; power of two, 2 or more.
- TIMEOUT, 64, WAIT-state cycles allowed before a timeout response; 2 or more.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- ReqVal  in  1  request valid.
- ReqRdy  out  1  request ready; equals 1 when the FIFO is not full.
- ReqDividend  in  WIDTH  dividend.
- ReqDivisor  in  WIDTH  divisor.
- ReqTag  in  TAGW  tag returned with the response.
- DivDataVal  out  1  one-cycle issue pulse to the divider.
- DivDividend  out  WIDTH  operand to the divider, registered.
- DivDivisor  out  WIDTH  operand to the divider, registered.
- DivResultVal  in  1  divider result pulse, exactly 1 cycle per operation.
- DivQuotient  in  WIDTH  divider quotient.
- DivRemainder  in  WIDTH  divider remainder.
- RspVal  out  1  response valid.
- RspRdy  in  1  response ready.
- RspQuotient  out  WIDTH  quotient.
- RspRemainder  out  WIDTH  remainder.
- RspTag  out  TAGW  tag of the originating request.
- RspDivZero  out  1  divisor was 0.
- RspTimeout  out  1  divider did not respond within TIMEOUT cycles.

Behaviour:
- Reset, asynchronous:
  - FIFO emptied, pointers and count = 0, FSM = IDLE.
  - Outputs: ReqRdy=1, DivDataVal=0, RspVal=0, RspDivZero=0, RspTimeout=0.
  - All data outputs = 0.
  - The divider shares RST. A reset mid-operation abandons the operation with no response.
- FIFO:
  - Push = ReqVal & ReqRdy. ReqRdy = (count != DEPTH), with no same-cycle pop bypass.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - ReqVal while ReqRdy=0 has no effect.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If count != 0, pop the head into the operation register (dividend, divisor, tag).
  - If the head divisor == 0, go to HOLD with Quotient = all-ones, Remainder = dividend, DivZero=1, Timeout=0.
  - Otherwise go to ISSUE.
  - If count == 0, stay in IDLE.
- ISSUE:
  - DivDataVal=1 for exactly this cycle, with DivDividend/DivDivisor driven from the operation register.
  - Clear the watchdog counter, then go to WAIT.
- WAIT:
  - If DivResultVal=1, capture DivQuotient/DivRemainder, set DivZero=0 and Timeout=0, go to HOLD.
  - Otherwise, if counter == TIMEOUT-1, go to HOLD with Quotient=0, Remainder=0, Timeout=1.
  - Otherwise increment the counter.
  - When DivResultVal and the final timeout cycle coincide, the result wins.
- HOLD:
  - RspVal=1. All Rsp* fields come from registers and stay stable until the handshake.
  - When RspRdy=1, the response is consumed and the FSM returns to IDLE, giving one bubble cycle between operations.
- DivResultVal arriving in IDLE, ISSUE or HOLD (for example a late result from a timed-out operation) is ignored.
- Latency:
  - Request accepted at cycle t: pop at t+1, DivDataVal at t+2, WAIT from t+3.
  - Divider pulse at cycle p: RspVal at p+1.
  - Divide-by-zero: RspVal at t+2.
- Ordering: responses are strictly in acceptance order.
- Capacity: DEPTH+1 requests can be outstanding (DEPTH in the FIFO plus one in the operation register).
- Watchdog counter width is $clog2(TIMEOUT).

Decomposition:
- Package div_pkg holds:
  - state enum div_q_state_e {IDLE, ISSUE, WAIT, HOLD};
  - packed struct div_req_t {dividend, divisor, tag}, parameterized through package localparams matching the defaults;
  - localparam for the all-ones divide-by-zero quotient.
- One sub-module, div_req_fifo: a synchronous FIFO of div_req_t with push/pop, full/empty and count, using asynchronous active-high reset on CLK/RST.
- The FSM, operation register and watchdog stay in div_issue_queue.

Test Plan:
- Division: req 100/7 tag 3, RspRdy=1, with the bench divider model replying 9 cycles after DivDataVal.
  - DivDataVal high for exactly 1 cycle carrying 100 and 7.
  - Response Q=14, R=2, tag 3, DivZero=0, Timeout=0.
- Divide-by-zero: req 5/0 tag 1.
  - DivDataVal never asserts.
  - RspVal 2 cycles after acceptance, with Q=8'hFF, R=5, tag 1, DivZero=1.
- Backpressure: 6 back-to-back requests with tags 0..5, RspRdy held 0.
  - Exactly 5 accepted; ReqRdy=0 afterwards; RspVal held with tag 0 and stable fields.
  - After RspRdy is released, responses return in order with tags 0..4.
- Timeout: the divider model never responds, TIMEOUT=64.
  - RspVal rises 65 cycles after the DivDataVal cycle, with Timeout=1, Q=0, R=0.
  - A late DivResultVal while in HOLD is ignored and produces no extra response.
- Result/timeout race: DivResultVal asserted on the final WAIT cycle, counter=63.
  - Response carries the divider data, with Timeout=0.
- Reset mid-WAIT: pulse RST while 3 requests are queued and one is in WAIT.
  - Immediately: RspVal=0, DivDataVal=0, ReqRdy=1.
  - A new req 9/3 tag 2 yields the only response: Q=3, R=0, tag 2.
